// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared widths, constants and helpers for the LED frame driver
package led_pkg;

    localparam int LED_W = 16;
    localparam int PWM_W = 8;
    localparam logic [LED_W-1:0] LED_DARK = 16'hFFFF;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    function automatic logic [LED_W-1:0] bit_reverse(input logic [LED_W-1:0] v);
        logic [LED_W-1:0] r;
        for (int i = 0; i < LED_W; i++) begin
            r[i] = v[LED_W-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/led_pwm_timer.sv
// rtl/led_pwm_timer.sv - clock prescaler and 8-bit PWM counter with period boundary strobe
module led_pwm_timer
    import led_pkg::*;
#(
    parameter int PRESCALE_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             tick,
    output logic             boundary,
    output logic [PWM_W-1:0] pwm_cnt
);

    // One spare bit keeps the prescaler legal when PRESCALE_W is 0.
    localparam int PS_BITS = PRESCALE_W + 1;
    localparam logic [PS_BITS-1:0] PS_MAX = PS_BITS'((1 << PRESCALE_W) - 1);

    logic [PS_BITS-1:0] presc_q, presc_d;
    logic [PWM_W-1:0]   pwm_q, pwm_d;

    always_comb begin
        tick     = (presc_q == PS_MAX);
        boundary = tick && (pwm_q == {PWM_W{1'b1}});
        presc_d  = tick ? '0 : presc_q + PS_BITS'(1);
        pwm_d    = tick ? pwm_q + PWM_W'(1) : pwm_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            pwm_q   <= '0;
        end else begin
            presc_q <= presc_d;
            pwm_q   <= pwm_d;
        end
    end

    assign pwm_cnt = pwm_q;

endmodule

// File: rtl/led_frame_driver.sv
// rtl/led_frame_driver.sv - single-slot frame buffer with period-aligned PWM LED output
module led_frame_driver
    import led_pkg::*;
#(
    parameter int PRESCALE_W = 4,
    parameter bit B_REVERSE  = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame_valid,
    output logic             frame_ready,
    input  logic [LED_W-1:0] frame_data,
    input  logic [PWM_W-1:0] brightness,
    output logic [LED_W-1:0] led_a,
    output logic [LED_W-1:0] led_b,
    output logic             frame_shown
);

    logic             tick;
    logic             boundary;
    logic [PWM_W-1:0] pwm_cnt;
    logic             period_end;
    logic             transfer;

    slot_state_e      state_q, state_d;
    logic [LED_W-1:0] pending_q, pending_d;
    logic [LED_W-1:0] active_q, active_d;
    logic [PWM_W-1:0] bright_q, bright_d;
    logic             shown_q, shown_d;
    logic [LED_W-1:0] led_a_q, led_a_d;

    led_pwm_timer #(
        .PRESCALE_W(PRESCALE_W)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .tick    (tick),
        .boundary(boundary),
        .pwm_cnt (pwm_cnt)
    );

    assign period_end  = tick && boundary;
    assign frame_ready = (state_q == SLOT_EMPTY);
    assign transfer    = frame_valid && frame_ready;

    // A frame accepted in the boundary cycle goes to pending; only a frame already
    // waiting in FULL is promoted to active on that boundary.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        active_d  = active_q;
        bright_d  = bright_q;
        shown_d   = 1'b0;
        unique case (state_q)
            SLOT_EMPTY: begin
                if (transfer) begin
                    pending_d = frame_data;
                    state_d   = SLOT_FULL;
                end
            end
            SLOT_FULL: begin
                if (period_end) begin
                    active_d = pending_q;
                    state_d  = SLOT_EMPTY;
                    shown_d  = 1'b1;
                end
            end
            default: state_d = SLOT_EMPTY;
        endcase
        if (period_end) begin
            bright_d = brightness;
        end
        led_a_d = (pwm_cnt < bright_q) ? active_q : LED_DARK;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= SLOT_EMPTY;
            pending_q <= LED_DARK;
            active_q  <= LED_DARK;
            bright_q  <= '0;
            shown_q   <= 1'b0;
            led_a_q   <= LED_DARK;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            active_q  <= active_d;
            bright_q  <= bright_d;
            shown_q   <= shown_d;
            led_a_q   <= led_a_d;
        end
    end

    assign led_a       = led_a_q;
    assign led_b       = B_REVERSE ? bit_reverse(led_a_q) : led_a_q;
    assign frame_shown = shown_q;

endmodule

// File: tb/tb_led_frame_driver.sv
// tb/tb_led_frame_driver.sv - directed self-checking bench for led_frame_driver
module tb_led_frame_driver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        frame_valid;
    logic [15:0] frame_data;
    logic [7:0]  brightness;

    logic        frame_ready, frame_shown;
    logic [15:0] led_a, led_b;
    logic        ready_r, shown_r;
    logic [15:0] led_a_r, led_b_r;

    int ecnt      = 0;
    int shown_cnt = 0;
    int pass_cnt  = 0;
    int check_cnt = 0;

    always #5 clk = ~clk;

    led_frame_driver #(.PRESCALE_W(4), .B_REVERSE(1'b0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_valid(frame_valid),
        .frame_ready(frame_ready),
        .frame_data (frame_data),
        .brightness (brightness),
        .led_a      (led_a),
        .led_b      (led_b),
        .frame_shown(frame_shown)
    );

    led_frame_driver #(.PRESCALE_W(4), .B_REVERSE(1'b1)) dut_r (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_valid(frame_valid),
        .frame_ready(ready_r),
        .frame_data (frame_data),
        .brightness (brightness),
        .led_a      (led_a_r),
        .led_b      (led_b_r),
        .frame_shown(shown_r)
    );

    // Edge index since reset release: 0 on the last edge in reset.
    always @(posedge clk) ecnt <= rst_n ? ecnt + 1 : 0;

    always @(negedge clk) if (frame_shown === 1'b1) shown_cnt <= shown_cnt + 1;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        check_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic goto(input int n);
        while (ecnt < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        frame_valid = 1'b0;
        frame_data  = 16'hFFFF;
        brightness  = 8'd128;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_led_a", led_a, 16'hFFFF);
        chk("rst_led_b", led_b, 16'hFFFF);
        chk("rst_ready", {15'd0, frame_ready}, 16'd1);
        chk("rst_shown", {15'd0, frame_shown}, 16'd0);
        rst_n = 1'b1;

        // Idle run
        goto(5000);
        chk("idle_led_a", led_a, 16'hFFFF);
        chk("idle_led_b_r", led_b_r, 16'hFFFF);
        chk("idle_ready", {15'd0, frame_ready}, 16'd1);
        chk("idle_shown_cnt", 16'(shown_cnt), 16'd0);

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single frame, 50% duty
        goto(9);
        frame_valid = 1'b1;
        frame_data  = 16'h30FF;
        goto(10);
        frame_valid = 1'b0;
        chk("f1_ready_low", {15'd0, frame_ready}, 16'd0);
        goto(4096);
        chk("f1_shown", {15'd0, frame_shown}, 16'd1);
        chk("f1_led_pre", led_a, 16'hFFFF);
        chk("f1_ready_back", {15'd0, frame_ready}, 16'd1);
        goto(4097);
        chk("f1_led_lit", led_a, 16'h30FF);
        chk("f1_led_b", led_b, 16'h30FF);
        chk("f1_led_b_rev", led_b_r, 16'hFF0C);
        chk("f1_shown_end", {15'd0, frame_shown}, 16'd0);
        goto(6144);
        chk("f1_last_lit", led_a, 16'h30FF);
        goto(6145);
        chk("f1_first_dark", led_a, 16'hFFFF);
        goto(8192);
        chk("f1_last_dark", led_a, 16'hFFFF);
        goto(8193);
        chk("f1_relit", led_a, 16'h30FF);
        chk("f1_shown_cnt", 16'(shown_cnt), 16'd1);

        // Back-to-back frames
        goto(8199);
        frame_valid = 1'b1;
        frame_data  = 16'h00FF;
        goto(8200);
        chk("b2b_ready_low", {15'd0, frame_ready}, 16'd0);
        frame_data = 16'hFFD5;
        goto(9000);
        chk("b2b_stall", {15'd0, frame_ready}, 16'd0);
        goto(12288);
        chk("b2b_ready_bnd", {15'd0, frame_ready}, 16'd1);
        goto(12289);
        chk("b2b_accept", {15'd0, frame_ready}, 16'd0);
        frame_valid = 1'b0;
        chk("b2b_first", led_a, 16'h00FF);
        goto(14000);
        chk("b2b_first_hold", led_a, 16'h00FF);
        goto(16385);
        chk("b2b_second", led_a, 16'hFFD5);
        chk("b2b_shown_cnt", 16'(shown_cnt), 16'd3);

        // Transfer in the boundary cycle
        goto(20479);
        frame_valid = 1'b1;
        frame_data  = 16'h5A5A;
        goto(20480);
        frame_valid = 1'b0;
        chk("bc_ready_low", {15'd0, frame_ready}, 16'd0);
        chk("bc_no_shown", {15'd0, frame_shown}, 16'd0);
        goto(20481);
        chk("bc_old_active", led_a, 16'hFFD5);
        goto(24576);
        chk("bc_shown_next", {15'd0, frame_shown}, 16'd1);
        goto(24577);
        chk("bc_new_active", led_a, 16'h5A5A);

        // Brightness 0 then 255
        goto(24580);
        brightness = 8'd0;
        goto(28700);
        chk("br0_dark", led_a, 16'hFFFF);
        goto(30000);
        brightness = 8'd255;
        goto(32000);
        chk("br_mid_dark", led_a, 16'hFFFF);
        goto(32768);
        chk("br_bnd_dark", led_a, 16'hFFFF);
        goto(32769);
        chk("br255_lit", led_a, 16'h5A5A);
        goto(36848);
        chk("br255_last_lit", led_a, 16'h5A5A);
        goto(36849);
        chk("br255_dark", led_a, 16'hFFFF);
        goto(36865);
        chk("br255_relit", led_a, 16'h5A5A);

        // Bit reverse
        goto(36899);
        frame_valid = 1'b1;
        frame_data  = 16'h0001;
        goto(36900);
        frame_valid = 1'b0;
        goto(40961);
        chk("rev_led_a", led_a, 16'h0001);
        chk("rev_led_b_copy", led_b, 16'h0001);
        chk("rev_led_a_r", led_a_r, 16'h0001);
        chk("rev_led_b_r", led_b_r, 16'h8000);
        chk("rev_shown_cnt", 16'(shown_cnt), 16'd5);

        // Reset while FULL
        goto(40999);
        frame_valid = 1'b1;
        frame_data  = 16'hFFF0;
        goto(41000);
        frame_valid = 1'b0;
        chk("rf_full", {15'd0, frame_ready}, 16'd0);
        goto(42000);
        rst_n = 1'b0;
        #1;
        chk("rf_led_a", led_a, 16'hFFFF);
        chk("rf_led_b_r", led_b_r, 16'hFFFF);
        chk("rf_ready", {15'd0, frame_ready}, 16'd1);
        chk("rf_shown", {15'd0, frame_shown}, 16'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        goto(9);
        frame_valid = 1'b1;
        frame_data  = 16'hA5A5;
        goto(10);
        frame_valid = 1'b0;
        chk("rf_accept", {15'd0, frame_ready}, 16'd0);
        goto(4095);
        chk("rf_pre_bnd_led", led_a, 16'hFFFF);
        chk("rf_pre_bnd_shown", {15'd0, frame_shown}, 16'd0);
        goto(4096);
        chk("rf_bnd_shown", {15'd0, frame_shown}, 16'd1);
        goto(4097);
        chk("rf_new_frame", led_a, 16'hA5A5);
        goto(4098);
        chk("rf_shown_cnt", 16'(shown_cnt), 16'd6);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/led_frame_driver.md
LED_FRAME_DRIVER -- requirements
Module: led_frame_driver

Interface
REQ-001 Parameter PRESCALE_W, default 4: PWM counter advances once per 2^PRESCALE_W clk cycles.
REQ-002 Parameter B_REVERSE, default 0: 1 = led_b is the bit-reversed image of led_a; 0 = identical copy.
REQ-003 clk  input  1  system clock, from OSCH internal oscillator at 12.09 MHz nominal.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 frame_valid  input  1  upstream sequencer offers frame_data.
REQ-006 frame_ready  output  1  block can accept a frame this cycle.
REQ-007 frame_data  input  16  LED pattern, active-low (0 = LED lit).
REQ-008 brightness  input  8  global duty; sampled at PWM period boundary only.
REQ-009 led_a  output  16  LED bank A, active-low.
REQ-010 led_b  output  16  LED bank B, active-low.
REQ-011 frame_shown  output  1  one-cycle pulse when a new frame becomes active.

Function
REQ-012 Transfer SHALL occur on a rising clk edge with frame_valid=1 and frame_ready=1; frame_data captured into the pending register.
REQ-013 Pending slot SHALL be a two-state machine: EMPTY (frame_ready=1), FULL (frame_ready=0); EMPTY->FULL on transfer, FULL->EMPTY on boundary load.
REQ-014 frame_ready SHALL be a registered function of state only, with no combinational path from frame_valid.
REQ-015 Prescaler SHALL count 0..2^PRESCALE_W-1 and wrap; its wrap cycle is the tick.
REQ-016 8-bit pwm_cnt SHALL increment on each tick, wrapping 255->0; the tick on which pwm_cnt wraps 255->0 is the period boundary.
REQ-017 At the boundary, if FULL: active <= pending, state <= EMPTY, frame_shown=1 on the next cycle for exactly one cycle.
REQ-018 At the boundary, bright_q <= brightness, independent of the pending state.
REQ-019 A transfer in the boundary cycle while EMPTY SHALL land in pending; active is unchanged until the following boundary.
REQ-020 A frame held in FULL SHALL never be overwritten or dropped; upstream stalls until it is loaded.
REQ-021 Lit phase = (pwm_cnt < bright_q); led_a = active in the lit phase, 16'hFFFF otherwise, registered with one clk latency.
REQ-022 bright_q=0 SHALL give all-dark outputs; bright_q=255 SHALL give a lit phase of 255 of 256 counts.
REQ-023 led_b SHALL equal led_a, or its bit-reverse when B_REVERSE=1, in the same cycle.
REQ-024 Period SHALL be 256*2^PRESCALE_W clk cycles (4096 at default, about 2.95 kHz).

Reset
REQ-025 While rst_n=0: state EMPTY, frame_ready=1 after release, prescaler=0, pwm_cnt=0, bright_q=0, active=16'hFFFF, pending=16'hFFFF, frame_shown=0, led_a=led_b=16'hFFFF.
REQ-026 Reset asserted mid-period or while FULL SHALL discard the pending frame; the first boundary after release is at cycle 4096.

Structure
REQ-027 Shared package led_pkg SHALL hold LED_W=16, PWM_W=8 and LED_DARK=16'hFFFF.
REQ-028 Prescaler and pwm_cnt SHALL live in sub-module led_pwm_timer, with outputs tick, boundary and pwm_cnt.
REQ-029 Target is MachXO2 with no vendor primitives inside this block; the OSCH clock is supplied by the top level.

Verification
REQ-030 Reset, then idle for 5000 cycles -> led_a=led_b=16'hFFFF, frame_ready=1, frame_shown never pulses.
REQ-031 brightness=128, frame_data=16'h30FF transferred at cycle 10 -> after the boundary at 4096, led_a=16'h30FF for 2048 cycles and 16'hFFFF for 2048 cycles each period; frame_shown pulses once.
REQ-032 Two back-to-back frames 16'h00FF then 16'hFFD5 -> second transfer stalls (frame_ready=0) until the first boundary, then is accepted and appears at the second boundary.
REQ-033 Transfer exactly in the boundary cycle -> active updates one boundary later, not on this one.
REQ-034 brightness changed 0->255 mid-period -> output stays dark until the next boundary, then 255/256 lit; B_REVERSE=1 with 16'h0001 -> led_b=16'h8000.
REQ-035 rst_n pulsed low while FULL -> outputs 16'hFFFF immediately, pending discarded, frame_ready=1.
